// File: rtl/atari_bus_pkg.sv
// Shared types and constants for the Atari 7800 cartridge-edge bus sequencer.
// Address-map constants live here so the decode stays in one place.
package atari_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } bus_state_t;

    localparam logic [11:0] POKEY_BASE = 12'h045;
    localparam logic [15:0] MENU_ADDR  = 16'h2200;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_TURNAROUND  = 2;

    // Width of the synchronised bundle {a, d, phi2, rw, halt}.
    localparam int BUNDLE_W = 16 + 8 + 3;

    function automatic logic is_rom_addr(input logic [15:0] addr);
        return addr[15] | addr[14];
    endfunction

    function automatic logic is_pokey_addr(input logic [15:0] addr);
        return addr[15:4] == POKEY_BASE;
    endfunction

    function automatic logic is_menu_addr(input logic [15:0] addr);
        return addr == MENU_ADDR;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-stage flop chain that brings the asynchronous Atari bus into the clk domain.
// Every bit shares the same depth, so a bundle moves across as one coherent word.
module bus_sync
    import atari_bus_pkg::*;
#(
    parameter int WIDTH  = BUNDLE_W,
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= raw;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/atari_bus_ctrl.sv
// Bus-cycle sequencer between the 7800 cartridge edge and the FPGA datapath.
// Owns the external buffer OE/DIR and turns CPU writes into single-cycle strobes.
module atari_bus_ctrl
    import atari_bus_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TURNAROUND  = DEFAULT_TURNAROUND
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_in,
    input  logic [7:0]  d_in,
    input  logic        phi2_in,
    input  logic        rw_in,
    input  logic        halt_in,
    output logic [15:0] a_sync,
    output logic        rom_drive,
    output logic        buf_oe,
    output logic        buf_dir,
    output logic        pokey_we,
    output logic [3:0]  pokey_addr,
    output logic [7:0]  wr_data,
    output logic        menu_wr,
    output logic [7:0]  menu_reg
);

    localparam int              CNT_W    = (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURNAROUND - 1);

    logic [BUNDLE_W-1:0] raw_bus;
    logic [BUNDLE_W-1:0] sync_bus;
    logic [15:0]         a_s;
    logic [7:0]          d_s;
    logic                phi2_s;
    logic                rw_s;
    logic                halt_s;

    assign raw_bus = {a_in, d_in, phi2_in, rw_in, halt_in};

    bus_sync #(
        .WIDTH  (BUNDLE_W),
        .STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw_bus),
        .synced (sync_bus)
    );

    assign {a_s, d_s, phi2_s, rw_s, halt_s} = sync_bus;
    assign a_sync = a_s;

    logic phi2_prev;
    logic phi2_fall;
    logic is_rom;
    logic is_pokey;
    logic is_menu;
    logic read_req;
    logic write_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_prev <= 1'b0;
        end else begin
            phi2_prev <= phi2_s;
        end
    end

    assign phi2_fall = phi2_prev & ~phi2_s;
    assign is_rom    = is_rom_addr(a_s);
    assign is_pokey  = is_pokey_addr(a_s);
    assign is_menu   = is_menu_addr(a_s);

    // DMA fetches (halt low) happen with phi2 low, so they bypass the phi2 qualifier.
    assign read_req  = is_rom & rw_s & (phi2_s | ~halt_s);
    assign write_req = ~rw_s & phi2_s & halt_s & (is_pokey | is_menu);

    bus_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             target_read, target_read_next;
    logic             wr_menu, wr_menu_next;
    logic [7:0]       hold, hold_next;
    logic             rom_drive_next;
    logic             buf_oe_next;
    logic             buf_dir_next;
    logic             pokey_we_next;
    logic [3:0]       pokey_addr_next;
    logic [7:0]       wr_data_next;
    logic             menu_wr_next;
    logic [7:0]       menu_reg_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            target_read <= 1'b0;
            wr_menu     <= 1'b0;
            hold        <= '0;
            rom_drive   <= 1'b0;
            buf_oe      <= 1'b1;
            buf_dir     <= 1'b0;
            pokey_we    <= 1'b0;
            pokey_addr  <= '0;
            wr_data     <= '0;
            menu_wr     <= 1'b0;
            menu_reg    <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            target_read <= target_read_next;
            wr_menu     <= wr_menu_next;
            hold        <= hold_next;
            rom_drive   <= rom_drive_next;
            buf_oe      <= buf_oe_next;
            buf_dir     <= buf_dir_next;
            pokey_we    <= pokey_we_next;
            pokey_addr  <= pokey_addr_next;
            wr_data     <= wr_data_next;
            menu_wr     <= menu_wr_next;
            menu_reg    <= menu_reg_next;
        end
    end

    // Outputs are computed one cycle ahead so they change on the same edge as the state.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        target_read_next = target_read;
        wr_menu_next     = wr_menu;
        hold_next        = d_s;
        rom_drive_next   = 1'b0;
        buf_oe_next      = 1'b1;
        buf_dir_next     = buf_dir;
        pokey_we_next    = 1'b0;
        pokey_addr_next  = pokey_addr;
        wr_data_next     = wr_data;
        menu_wr_next     = 1'b0;
        menu_reg_next    = menu_reg;

        case (state)
            IDLE: begin
                if (read_req) begin
                    if (buf_dir) begin
                        state_next     = READ;
                        buf_oe_next    = 1'b0;
                        rom_drive_next = 1'b1;
                    end else begin
                        state_next       = TURN;
                        target_read_next = 1'b1;
                        buf_dir_next     = 1'b1;
                        cnt_next         = CNT_LOAD;
                    end
                end else if (write_req) begin
                    if (!buf_dir) begin
                        state_next      = WRITE;
                        buf_oe_next     = 1'b0;
                        pokey_addr_next = a_s[3:0];
                        wr_menu_next    = is_menu;
                    end else begin
                        state_next       = TURN;
                        target_read_next = 1'b0;
                        buf_dir_next     = 1'b0;
                        cnt_next         = CNT_LOAD;
                    end
                end
            end

            TURN: begin
                if (cnt == '0) begin
                    if (target_read && read_req) begin
                        state_next     = READ;
                        buf_oe_next    = 1'b0;
                        rom_drive_next = 1'b1;
                    end else if (!target_read && write_req) begin
                        state_next      = WRITE;
                        buf_oe_next     = 1'b0;
                        pokey_addr_next = a_s[3:0];
                        wr_menu_next    = is_menu;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            READ: begin
                if (read_req) begin
                    buf_oe_next    = 1'b0;
                    rom_drive_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end

            WRITE: begin
                // hold still carries the last sample taken while phi2 was high.
                if (phi2_fall) begin
                    wr_data_next = hold;
                    if (wr_menu) begin
                        menu_wr_next  = 1'b1;
                        menu_reg_next = hold;
                    end else begin
                        pokey_we_next = 1'b1;
                    end
                    state_next = IDLE;
                end else if (rw_s || !halt_s) begin
                    state_next = IDLE;
                end else begin
                    buf_oe_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
